// File: rtl/booth_pkg.sv
// Shared types, radix selection and step-count helper for the sequential Booth multiplier.
// Defining BOOTH_RADIX4_EN selects modified Booth radix-4; otherwise radix-2 is built.
package booth_pkg;

    typedef enum logic {
        ST_IDLE,
        ST_RUN
    } state_e;

    typedef enum logic [2:0] {
        OP_NONE,
        OP_ADD,
        OP_SUB,
        OP_ADD2,
        OP_SUB2
    } op_e;

`ifdef BOOTH_RADIX4_EN
    localparam int unsigned BoothShift = 2;
`else
    localparam int unsigned BoothShift = 1;
`endif

    // Guard bits on the accumulator so negating/doubling the most-negative mcand cannot overflow.
    localparam int unsigned AccExtra = BoothShift;
    localparam int unsigned RecodeW  = BoothShift + 1;

    function automatic int unsigned booth_steps(input int unsigned width);
        return (width + BoothShift - 1) / BoothShift;
    endfunction

    function automatic op_e booth_recode(input logic [RecodeW-1:0] bits);
        op_e op;
        op = OP_NONE;
`ifdef BOOTH_RADIX4_EN
        case (bits)
            3'b001, 3'b010: op = OP_ADD;
            3'b011:         op = OP_ADD2;
            3'b100:         op = OP_SUB2;
            3'b101, 3'b110: op = OP_SUB;
            default:        op = OP_NONE;
        endcase
`else
        case (bits)
            2'b01:   op = OP_ADD;
            2'b10:   op = OP_SUB;
            default: op = OP_NONE;
        endcase
`endif
        return op;
    endfunction

endpackage

// File: rtl/booth_step.sv
// One combinational Booth step: recode, add/subtract mcand into the accumulator, then
// arithmetic-shift the whole partial-product register right. Holds the block's only adder.
module booth_step
    import booth_pkg::*;
#(
    parameter int unsigned AccW = 7,
    parameter int unsigned LowW = 7
) (
    input  logic [AccW-1:0]      acc_i,
    input  logic [LowW-1:0]      low_i,
    input  logic [AccW-1:0]      mcand_i,
    input  logic [RecodeW-1:0]   recode_i,
    output logic [AccW+LowW-1:0] p_o
);

    op_e                           op;
    logic [AccW-1:0]               addend;
    logic                          cin;
    logic [AccW-1:0]               sum;
    logic signed [AccW+LowW-1:0]   cat;

    always_comb begin
        op     = booth_recode(recode_i);
        addend = '0;
        cin    = 1'b0;
        case (op)
            OP_ADD:  addend = mcand_i;
            OP_SUB: begin
                addend = ~mcand_i;
                cin    = 1'b1;
            end
            OP_ADD2: addend = mcand_i << 1;
            OP_SUB2: begin
                addend = ~(mcand_i << 1);
                cin    = 1'b1;
            end
            default: begin
                addend = '0;
                cin    = 1'b0;
            end
        endcase
    end

    always_comb begin
        sum = acc_i + addend + AccW'(cin);
        cat = {sum, low_i};
        p_o = cat >>> BoothShift;
    end

endmodule

// File: rtl/booth_seq_mult.sv
// Iterative signed Booth multiplier: one recoding step per clock, full 2*WIDTH-bit product.
// Build with BOOTH_RADIX4_EN defined for the radix-4 variant (half the steps).
module booth_seq_mult
    import booth_pkg::*;
#(
    parameter int unsigned WIDTH = 6
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [WIDTH-1:0]   in1,
    input  logic [WIDTH-1:0]   in2,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] out
);

    localparam int unsigned NSteps = booth_steps(WIDTH);
    localparam int unsigned AccW   = WIDTH + AccExtra;
    // Multiplier field is sign-extended to a whole number of steps (odd WIDTH in radix-4).
    localparam int unsigned MultW  = NSteps * BoothShift;
    localparam int unsigned LowW   = MultW + 1;
    localparam int unsigned PW     = AccW + LowW;
    localparam int unsigned CntW   = $clog2(NSteps) + 1;
    localparam logic [CntW-1:0] LastCnt = CntW'(NSteps - 1);

    state_e             state_q;
    logic [PW-1:0]      p_q;
    logic [PW-1:0]      p_d;
    logic [AccW-1:0]    mcand_q;
    logic [CntW-1:0]    cnt_q;
    logic [2*WIDTH-1:0] out_q;
    logic               busy_q;
    logic               done_q;

    booth_step #(
        .AccW(AccW),
        .LowW(LowW)
    ) u_step (
        .acc_i   (p_q[PW-1 -: AccW]),
        .low_i   (p_q[LowW-1:0]),
        .mcand_i (mcand_q),
        .recode_i(p_q[RecodeW-1:0]),
        .p_o     (p_d)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            p_q     <= '0;
            mcand_q <= '0;
            cnt_q   <= '0;
            out_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        p_q     <= {{AccW{1'b0}}, MultW'($signed(in2)), 1'b0};
                        mcand_q <= AccW'($signed(in1));
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    p_q   <= p_d;
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == LastCnt) begin
                        // Bit 0 of P is the q_1 history bit, not part of the product.
                        out_q   <= p_d[2*WIDTH:1];
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= ST_IDLE;
                    end
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign out  = out_q;

endmodule

// File: tb/tb_booth_seq_mult.sv
// Self-checking bench for booth_seq_mult at WIDTH=6 against a plain signed-multiply model.
module tb_booth_seq_mult;

`ifdef BOOTH_RADIX4_EN
    localparam int N = 3;
`else
    localparam int N = 6;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [5:0]  in1 = '0;
    logic [5:0]  in2 = '0;
    logic        busy;
    logic        done;
    logic [11:0] prod;

    int          n_checks = 0;
    int          n_fail = 0;
    logic [11:0] last_exp = '0;
    logic [5:0]  ha [0:31];
    logic [5:0]  hb [0:31];

    booth_seq_mult #(
        .WIDTH(6)
    ) dut (
        .clk  (clk),
        .rst  (rst),
        .start(start),
        .in1  (in1),
        .in2  (in2),
        .busy (busy),
        .done (done),
        .out  (prod)
    );

    always #5 clk = ~clk;

    function automatic logic [11:0] model(input logic [5:0] a, input logic [5:0] b);
        int p;
        p = int'($signed(a)) * int'($signed(b));
        return p[11:0];
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_checks++;
        assert (obs === exp_v) else begin
            n_fail++;
            $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp_v);
        end
    endtask

    task automatic run_op(input logic [5:0] a, input logic [5:0] b, input string tag,
                          input bit full);
        int lat;
        start = 1'b1;
        in1   = a;
        in2   = b;
        tick();
        start = 1'b0;
        in1   = 6'($urandom);
        in2   = 6'($urandom);
        if (full) check({tag, " busy_after_accept"}, 32'(busy), 1);
        lat = 0;
        while (!done && lat < 40) begin
            tick();
            lat++;
        end
        if (!done) check({tag, " done_timeout"}, 32'(done), 1);
        last_exp = model(a, b);
        check({tag, " product"}, 32'(prod), 32'(last_exp));
        if (full) begin
            check({tag, " latency"}, 32'(lat), 32'(N));
            check({tag, " busy_at_done"}, 32'(busy), 0);
            tick();
            check({tag, " done_one_cycle"}, 32'(done), 0);
            check({tag, " out_held"}, 32'(prod), 32'(last_exp));
        end
    endtask

    initial begin
        // Reset
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        tick();
        check("reset busy", 32'(busy), 0);
        check("reset done", 32'(done), 0);
        check("reset out", 32'(prod), 0);

        // Directed vectors
        run_op(6'd3, 6'd5, "3x5", 1);
        check("3x5 const", 32'(prod), 32'h00F);
        run_op(6'b100000, 6'b100000, "m32xm32", 1);
        check("m32xm32 const", 32'(prod), 32'h400);
        run_op(6'b100000, 6'd31, "m32x31", 1);
        check("m32x31 const", 32'(prod), 32'hC20);
        run_op(6'd7, 6'b111111, "7xm1", 1);
        check("7xm1 const", 32'(prod), 32'hFF9);

        // Random operands
        repeat (8) run_op(6'($urandom), 6'($urandom), "rand", 1);

        // start held high with operands changing every cycle
        for (int c = 0; c < 3 * (N + 1); c++) begin
            ha[c] = 6'($urandom);
            hb[c] = 6'($urandom);
            in1   = ha[c];
            in2   = hb[c];
            start = 1'b1;
            tick();
            if (c % (N + 1) == N) begin
                last_exp = model(ha[c-N], hb[c-N]);
                check("held done", 32'(done), 1);
                check("held busy_low", 32'(busy), 0);
            end else begin
                check("held no_done", 32'(done), 0);
                check("held busy_high", 32'(busy), 1);
            end
            check("held out", 32'(prod), 32'(last_exp));
        end
        start = 1'b0;
        tick();
        check("held idle after", 32'(busy), 0);

        // Reset on step 3 discards the operation
        start = 1'b1;
        in1   = 6'd21;
        in2   = 6'd13;
        tick();
        start = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        last_exp = '0;
        check("midrst busy", 32'(busy), 0);
        check("midrst done", 32'(done), 0);
        check("midrst out", 32'(prod), 0);
        for (int i = 0; i < 12; i++) begin
            tick();
            check("midrst no_done", 32'(done), 0);
            check("midrst out_zero", 32'(prod), 0);
        end
        run_op(6'd21, 6'd13, "after_rst", 1);

        // Exhaustive operand sweep
        for (int a = 0; a < 64; a++) begin
            for (int b = 0; b < 64; b++) begin
                run_op(6'(a), 6'(b), "sweep", 0);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
